act_feeder: RTL and testbench

ACT_FEEDER -- requirements
Module: act_feeder

---
 rtl/ftdl_pkg.sv | 13 +
 rtl/act_fifo.sv | 64 ++++++
 rtl/ftdl_conf.vh | 7 +
 rtl/act_feeder.sv | 122 ++++++++++++
 tb/tb_act_feeder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ftdl_pkg.sv
// rtl/ftdl_pkg.sv - shared types and constants for the activation feeder
`include "ftdl_conf.vh"

package ftdl_pkg;

    localparam int ACT_DATA_W = 2 * `ACTBUF_DATA_LEN;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } feed_state_t;

endpackage

// File: rtl/act_fifo.sv
// rtl/act_fifo.sv - power-of-two staging FIFO with registered occupancy count
module act_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk_l,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer width equals log2(DEPTH), so increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_l) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ftdl_conf.vh
// rtl/ftdl_conf.vh - shared build configuration for the activation datapath
`ifndef FTDL_CONF_VH
`define FTDL_CONF_VH

`define ACTBUF_DATA_LEN 8

`endif

// File: rtl/act_feeder.sv
// rtl/act_feeder.sv - feeds staged activation words to the buffer in requested bursts
`include "ftdl_conf.vh"

module act_feeder
    import ftdl_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    parameter  int PEND_MAX   = 3,
    parameter  int BL_W       = 8,
    localparam int DATA_W     = 2 * `ACTBUF_DATA_LEN
) (
    input  logic              clk_l,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              actbuf_wr_req,
    output logic [DATA_W-1:0] actbuf_wr_data,
    output logic              actbuf_wr_vld,
    input  logic [BL_W-1:0]   cfg_burst_len,
    output logic              feed_busy,
    output logic              req_ovf,
    input  logic              ovf_clr
);

    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

    feed_state_t       state_q, state_d;
    logic [PW-1:0]     pend_q, pend_d;
    logic [BL_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q;
    logic              ovf_q, ovf_d;
    logic              rdy_en_q;

    logic              start, pop, accept, drop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [CW-1:0]     unused_fifo_count;

    act_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_l       (clk_l),
        .rst_n       (rst_n),
        .push_i      (in_vld && in_rdy),
        .push_data_i (in_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (unused_fifo_count)
    );

    // rdy_en_q keeps in_rdy low until the first clock after reset release.
    assign in_rdy         = rdy_en_q && !fifo_full;
    assign feed_busy      = (state_q == BURST);
    assign actbuf_wr_data = data_q;
    assign actbuf_wr_vld  = vld_q;
    assign req_ovf        = ovf_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        start   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    start   = 1'b1;
                    state_d = BURST;
                    beat_d  = cfg_burst_len;
                end
            end
            BURST: begin
                if (beat_q == '0) begin
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    pop    = 1'b1;
                    beat_d = beat_q - 1'b1;
                    if (beat_q == BL_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full queue still admits a request if a burst leaves it this cycle.
    always_comb begin
        accept = actbuf_wr_req && ((pend_q != PEND_FULL) || start);
        drop   = actbuf_wr_req && !accept;
        pend_d = pend_q;
        if (accept && !start)      pend_d = pend_q + 1'b1;
        else if (!accept && start) pend_d = pend_q - 1'b1;
        ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        data_d = pop ? fifo_rd_data : data_q;
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            beat_q   <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            beat_q   <= beat_d;
            data_q   <= data_d;
            vld_q    <= pop;
            ovf_q    <= ovf_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_act_feeder.sv
// tb/tb_act_feeder.sv - self-checking bench for act_feeder
module tb_act_feeder;
    import ftdl_pkg::*;

    localparam int DW = ACT_DATA_W;

    logic          clk_l = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic          actbuf_wr_req = 1'b0;
    logic [DW-1:0] actbuf_wr_data;
    logic          actbuf_wr_vld;
    logic [7:0]    cfg_burst_len = '0;
    logic          feed_busy;
    logic          req_ovf;
    logic          ovf_clr = 1'b0;

    act_feeder #(.FIFO_DEPTH(8), .PEND_MAX(3), .BL_W(8)) dut (
        .clk_l          (clk_l),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .actbuf_wr_req  (actbuf_wr_req),
        .actbuf_wr_data (actbuf_wr_data),
        .actbuf_wr_vld  (actbuf_wr_vld),
        .cfg_burst_len  (cfg_burst_len),
        .feed_busy      (feed_busy),
        .req_ovf        (req_ovf),
        .ovf_clr        (ovf_clr)
    );

    always #5 clk_l = ~clk_l;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every accepted word must come out once, in arrival order.
    logic [DW-1:0] exp_q[$];
    int            beats = 0;
    int            rises = 0;
    logic          busy_prev = 1'b0;

    always @(posedge clk_l) begin
        if (rst_n && in_vld && in_rdy) exp_q.push_back(in_data);
    end

    always @(negedge clk_l) begin
        if (!rst_n) begin
            exp_q.delete();
            busy_prev = 1'b0;
        end else begin
            if (actbuf_wr_vld) begin
                beats++;
                chk("beat_has_word", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("order_data", 32'(actbuf_wr_data), 32'(exp_q.pop_front()));
            end
            if (feed_busy && !busy_prev) rises++;
            busy_prev = feed_busy;
        end
    end

    task automatic tick();
        @(posedge clk_l);
        #1;
    endtask

    task automatic pulse_req();
        actbuf_wr_req = 1'b1;
        tick();
        actbuf_wr_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b, r, acc, need, len, nreq, cyc;

        // Reset values
        repeat (3) tick();
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_vld", 32'(actbuf_wr_vld), 32'd0);
        chk("rst_data", 32'(actbuf_wr_data), 32'd0);
        chk("rst_busy", 32'(feed_busy), 32'd0);
        chk("rst_ovf", 32'(req_ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", 32'(in_rdy), 32'd1);

        // Preload A0..A3, burst of 4: beats at t+3..t+6
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(16'h00A0 + i);
            in_vld  = 1'b1;
            tick();
        end
        in_vld = 1'b0;
        cfg_burst_len = 8'd4;
        pulse_req();
        for (int k = 1; k <= 8; k++) begin
            chk("t1_vld", 32'(actbuf_wr_vld), 32'(k >= 3 && k <= 6));
            chk("t1_busy", 32'(feed_busy), 32'(k >= 2 && k <= 5));
            if (k >= 3 && k <= 6) chk("t1_data", 32'(actbuf_wr_data), 32'(16'h00A0 + k - 3));
            else if (k > 6) chk("t1_hold", 32'(actbuf_wr_data), 32'h00A3);
            tick();
        end

        // Empty FIFO, burst of 3, one word every 5 cycles
        cfg_burst_len = 8'd3;
        b = beats;
        pulse_req();
        for (int w = 0; w < 4; w++) begin
            in_data = DW'(16'h00B0 + w);
            in_vld  = 1'b1;
            tick();
            in_vld = 1'b0;
            chk("t2_gap0", 32'(actbuf_wr_vld), 32'd0);
            tick();
            chk("t2_beat", 32'(actbuf_wr_vld), 32'(w < 3));
            for (int g = 0; g < 3; g++) begin
                tick();
                chk("t2_gap", 32'(actbuf_wr_vld), 32'd0);
            end
        end
        chk("t2_beats", 32'(beats - b), 32'd3);
        chk("t2_idle", 32'(feed_busy), 32'd0);

        // Zero-length burst: one BURST cycle, no beats
        cfg_burst_len = 8'd0;
        b = beats;
        pulse_req();
        chk("len0_c1", 32'(feed_busy), 32'd0);
        tick();
        chk("len0_c2", 32'(feed_busy), 32'd1);
        tick();
        chk("len0_c3", 32'(feed_busy), 32'd0);
        repeat (4) tick();
        chk("len0_beats", 32'(beats - b), 32'd0);

        // Overflow: long stalled burst, 5 requests, set wins over clear
        cfg_burst_len = 8'd20;
        b = beats;
        r = rises;
        pulse_req();
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ovf_clr = 1'b1;
            pulse_req();
            ovf_clr = 1'b0;
            chk("ovf_seq", 32'(req_ovf), 32'(i >= 3));
            tick();
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(req_ovf), 32'd0);
        cfg_burst_len = 8'd2;
        acc = 0;
        cyc = 0;
        in_vld = 1'b1;
        while (acc < 25 && cyc < 400) begin
            in_data = DW'($urandom);
            if (in_rdy) acc++;
            tick();
            cyc++;
        end
        in_vld = 1'b0;
        repeat (40) tick();
        chk("ovf_beats", 32'(beats - b), 32'd26);
        chk("ovf_bursts", 32'(rises - r), 32'd4);

        // Fill to full; a pop does not admit a push in the same cycle
        cfg_burst_len = 8'd1;
        acc = 0;
        in_vld = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = DW'($urandom);
            if (in_rdy) acc++;
            tick();
        end
        chk("fill_count", 32'(acc), 32'd8);
        chk("fill_rdy", 32'(in_rdy), 32'd0);
        pulse_req();
        chk("full_t1", 32'(in_rdy), 32'd0);
        tick();
        chk("full_pop_cycle", 32'(in_rdy), 32'd0);
        tick();
        chk("full_after_pop", 32'(in_rdy), 32'd1);
        tick();
        in_vld = 1'b0;
        chk("full_again", 32'(in_rdy), 32'd0);

        // Reset in the middle of an 8-word burst
        cfg_burst_len = 8'd8;
        pulse_req();
        repeat (4) tick();
        chk("mid_burst_vld", 32'(actbuf_wr_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", 32'(actbuf_wr_vld), 32'd0);
        chk("rst_mid_busy", 32'(feed_busy), 32'd0);
        chk("rst_mid_rdy", 32'(in_rdy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        b = beats;
        repeat (15) tick();
        chk("post_rst_beats", 32'(beats - b), 32'd0);
        cfg_burst_len = 8'd1;
        pulse_req();
        repeat (8) tick();
        chk("post_rst_empty", 32'(beats - b), 32'd0);
        in_data = DW'(16'h5A5A);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        repeat (4) tick();
        chk("post_rst_one", 32'(beats - b), 32'd1);

        // Randomised batches
        for (int n = 0; n < 20; n++) begin
            len  = $urandom_range(0, 5);
            nreq = $urandom_range(1, 3);
            cfg_burst_len = 8'(len);
            b = beats;
            r = rises;
            for (int i = 0; i < nreq; i++) begin
                pulse_req();
                tick();
            end
            need = len * nreq;
            acc = 0;
            cyc = 0;
            while (acc < need && cyc < 500) begin
                in_vld  = 1'($urandom_range(0, 1));
                in_data = DW'($urandom);
                if (in_vld && in_rdy) acc++;
                tick();
                cyc++;
            end
            in_vld = 1'b0;
            repeat (15) tick();
            chk("rnd_beats", 32'(beats - b), 32'(need));
            chk("rnd_bursts", 32'(rises - r), 32'(nreq));
            chk("rnd_ovf", 32'(req_ovf), 32'd0);
        end
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
